// File: rtl/rptr_handler_lvl_if.sv
// rptr_handler_lvl_if: read-domain pointer controller signal bundle.
interface rptr_handler_lvl_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 r_en;
    logic                 ufl_clr;
    logic [PTR_WIDTH:0]   g_wptr_sync;
    logic [PTR_WIDTH:0]   b_rptr;
    logic [PTR_WIDTH:0]   g_rptr;
    logic [PTR_WIDTH:0]   rd_level;
    logic                 empty;
    logic                 almost_empty;
    logic                 rd_valid;
    logic                 underflow;
    logic                 underflow_sticky;

    modport slave (
        input  r_en, ufl_clr, g_wptr_sync,
        output b_rptr, g_rptr, rd_level, empty, almost_empty, rd_valid, underflow, underflow_sticky
    );

    modport master (
        output r_en, ufl_clr, g_wptr_sync,
        input  b_rptr, g_rptr, rd_level, empty, almost_empty, rd_valid, underflow, underflow_sticky
    );
endinterface

// File: rtl/rptr_handler_lvl.sv
// rptr_handler_lvl: async FIFO read pointers, registered empty/level/almost-empty, underflow flags.
module rptr_handler_lvl #(
    parameter int PTR_WIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              clk_r,
    input  logic              arst,
    rptr_handler_lvl_if.slave bus
);
    localparam logic [PTR_WIDTH:0] AE = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d, g_rptr_q, g_rptr_d, level_q, level_d, b_wptr;
    logic               empty_q, ae_q, valid_q, ufl_q, sticky_q, accept;

    always_comb begin
        accept   = bus.r_en & ~empty_q;
        b_rptr_d = b_rptr_q + {{PTR_WIDTH{1'b0}}, accept};
        g_rptr_d = (b_rptr_d >> 1) ^ b_rptr_d;
        b_wptr   = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) b_wptr[i] = ^(bus.g_wptr_sync >> i);
        level_d  = b_wptr - b_rptr_d;
    end

    always_ff @(posedge clk_r) begin
        if (arst) begin
            b_rptr_q <= '0;
            g_rptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            valid_q  <= 1'b0;
            ufl_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            b_rptr_q <= b_rptr_d;
            g_rptr_q <= g_rptr_d;
            level_q  <= level_d;
            empty_q  <= bus.g_wptr_sync == g_rptr_d;
            ae_q     <= level_d <= AE;
            valid_q  <= accept;
            ufl_q    <= bus.r_en & empty_q;
            sticky_q <= (sticky_q & ~bus.ufl_clr) | (bus.r_en & empty_q);
        end
    end

    assign bus.b_rptr           = b_rptr_q;
    assign bus.g_rptr           = g_rptr_q;
    assign bus.rd_level         = level_q;
    assign bus.empty            = empty_q;
    assign bus.almost_empty     = ae_q;
    assign bus.rd_valid         = valid_q;
    assign bus.underflow        = ufl_q;
    assign bus.underflow_sticky = sticky_q;
endmodule

// File: tb/tb_rptr_handler_lvl.sv
// tb_rptr_handler_lvl: table-driven scoreboard bench for rptr_handler_lvl (PTR_WIDTH=3, AE_THRESH=2).
module tb_rptr_handler_lvl;
    typedef struct {
        logic       rst, r_en, clr;
        logic [3:0] gw, b, g, lvl;
        logic       e, ae, v, u, s;
    } vec_t;

    logic clk_r = 1'b0;
    logic arst  = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t exp_q[$];
    logic [3:0] gray_lut [16];
    logic [3:0] prev_g;

    rptr_handler_lvl_if #(.PTR_WIDTH(3)) bus ();
    rptr_handler_lvl #(.PTR_WIDTH(3), .AE_THRESH(2)) dut (.clk_r(clk_r), .arst(arst), .bus(bus));

    always #5 clk_r = ~clk_r;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, r_en, clr, input logic [3:0] gw, b, g, lvl,
                                input logic e, ae, v, u, s);
        vec_t t;
        t.rst = rst; t.r_en = r_en; t.clr = clr; t.gw = gw;
        t.b = b; t.g = g; t.lvl = lvl; t.e = e; t.ae = ae; t.v = v; t.u = u; t.s = s;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t x;
        exp_q.push_back(t);
        arst            = t.rst;
        bus.r_en        = t.r_en;
        bus.ufl_clr     = t.clr;
        bus.g_wptr_sync = t.gw;
        @(posedge clk_r);
        #1;
        x = exp_q.pop_front();
        chk("b_rptr", idx, bus.b_rptr, x.b);
        chk("g_rptr", idx, bus.g_rptr, x.g);
        chk("rd_level", idx, bus.rd_level, x.lvl);
        chk("empty", idx, {3'b0, bus.empty}, {3'b0, x.e});
        chk("almost_empty", idx, {3'b0, bus.almost_empty}, {3'b0, x.ae});
        chk("rd_valid", idx, {3'b0, bus.rd_valid}, {3'b0, x.v});
        chk("underflow", idx, {3'b0, bus.underflow}, {3'b0, x.u});
        chk("underflow_sticky", idx, {3'b0, bus.underflow_sticky}, {3'b0, x.s});
    endtask

    initial begin
        gray_lut = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        bus.r_en = 1'b0; bus.ufl_clr = 1'b0; bus.g_wptr_sync = '0;
        //      rst r  clr gw   b   g   lvl  e ae v u s
        tbl.push_back(mk(1, 0, 0, 4'h0, 4'd0,  4'h0, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 4'd0,  4'h0, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h7, 4'd0,  4'h0, 4'd5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd1,  4'h1, 4'd4, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd2,  4'h3, 4'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd3,  4'h2, 4'd2, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd4,  4'h6, 4'd1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 4'h7, 4'd5,  4'h7, 4'd0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'h5, 4'd5,  4'h7, 4'd1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h4, 4'd6,  4'h5, 4'd1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'h9, 4'd6,  4'h5, 4'd8, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd7,  4'h4, 4'd7, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd8,  4'hC, 4'd6, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd9,  4'hD, 4'd5, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd10, 4'hF, 4'd4, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd11, 4'hE, 4'd3, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd12, 4'hA, 4'd2, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd13, 4'hB, 4'd1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h9, 4'd14, 4'h9, 4'd0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h8, 4'd14, 4'h9, 4'd1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h1, 4'd15, 4'h8, 4'd2, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h1, 4'd0,  4'h0, 4'd1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4'h1, 4'd1,  4'h1, 4'd0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 4'h1, 4'd1,  4'h1, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 4'h7, 4'd1,  4'h1, 4'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd2,  4'h3, 4'd3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h7, 4'd0,  4'h0, 4'd0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd0,  4'h0, 4'd5, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h7, 4'd1,  4'h1, 4'd4, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 4'h7, 4'd1,  4'h1, 4'd4, 0, 0, 0, 0, 1));
        foreach (tbl[i]) apply(tbl[i], i);

        // Full lap: fill to 8 then drain, checking one-bit Gray steps.
        apply(mk(1, 0, 0, 4'h0, 4'd0, 4'h0, 4'd0, 1, 1, 0, 0, 0), 100);
        apply(mk(0, 0, 0, 4'hC, 4'd0, 4'h0, 4'd8, 0, 0, 0, 0, 0), 101);
        prev_g = bus.g_rptr;
        for (int k = 1; k <= 8; k++) begin
            apply(mk(0, 1, 0, 4'hC, 4'(k), gray_lut[k], 4'(8 - k), k == 8, (8 - k) <= 2, 1, 0, 0), 101 + k);
            chk("gray_one_bit", 101 + k, 4'($countones(bus.g_rptr ^ prev_g)), 4'd1);
            prev_g = bus.g_rptr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
